life_cell_renderer: RTL and testbench



---
 rtl/life_cell_renderer.sv | 135 +++++++++++++
 tb/tb_life_cell_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/life_cell_renderer.sv
// Pixel-colour stage for the Game of Life display: maps VGA counts onto 20x20 cells
// of a double-buffered bitmap and swaps banks only at frame boundaries.
module life_cell_renderer #(
  parameter int          CELL_PX     = 20,
  parameter int          GRID_W      = 32,
  parameter int          GRID_H      = 24,
  parameter int          H_ACT_START = 144,
  parameter int          V_ACT_START = 35,
  parameter int          H_SYNC_END  = 96,
  parameter int          V_SYNC_END  = 2,
  parameter logic [11:0] ALIVE_RGB   = 12'hFFF,
  parameter logic [11:0] DEAD_RGB    = 12'h000,
  parameter logic [11:0] GRID_RGB    = 12'h444,
  parameter bit          SHOW_GRID   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        use_enable,
  input  logic [15:0] h_count,
  input  logic [15:0] v_count,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_addr,
  input  logic        wr_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        hsync_vga,
  output logic        vsync_vga,
  output logic [3:0]  r_vga,
  output logic [3:0]  g_vga,
  output logic [3:0]  b_vga
);

  localparam int          CELLS   = GRID_W * GRID_H;
  localparam logic [15:0] H_START = 16'(H_ACT_START);
  localparam logic [15:0] V_START = 16'(V_ACT_START);
  localparam logic [15:0] H_WIDTH = 16'(GRID_W * CELL_PX);
  localparam logic [15:0] V_WIDTH = 16'(GRID_H * CELL_PX);
  localparam logic [15:0] PX      = 16'(CELL_PX);
  localparam logic [10:0] N_CELLS = 11'(CELLS);

  logic [CELLS-1:0] r_bank0, r_bank1;
  logic             r_bank_sel, r_swap_pending, r_swap_ack;

  logic             r_s1_active, r_s1_grid, r_s1_cell, r_s1_hsync, r_s1_vsync;
  logic             r_hsync, r_vsync;
  logic [11:0]      r_rgb;

  logic             w_boundary, w_wr_fire, w_active, w_h_act, w_v_act, w_grid, w_cell;
  logic [15:0]      w_hx, w_vy, w_col, w_row;
  logic [9:0]       w_idx;
  logic [CELLS-1:0] w_front;
  logic [11:0]      w_rgb;

  assign wr_ready   = !r_swap_pending && !rst;
  assign w_wr_fire  = wr_valid && wr_ready;
  assign w_boundary = use_enable && (h_count == 16'd0) && (v_count == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank0        <= '0;
      r_bank1        <= '0;
      r_bank_sel     <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_ack     <= 1'b0;
    end else begin
      r_swap_ack <= w_boundary && r_swap_pending;
      if (w_boundary && r_swap_pending) begin
        r_bank_sel     <= ~r_bank_sel;
        r_swap_pending <= 1'b0;
      end else if (swap_req && !r_swap_pending) begin
        r_swap_pending <= 1'b1;
      end
      // Writes land in the bank that is not on screen; out-of-grid addresses vanish.
      if (w_wr_fire && ({1'b0, wr_addr} < N_CELLS)) begin
        if (r_bank_sel) r_bank0[wr_addr] <= wr_data;
        else            r_bank1[wr_addr] <= wr_data;
      end
    end
  end

  assign swap_ack = r_swap_ack;

  always_comb begin
    w_hx     = h_count - H_START;
    w_vy     = v_count - V_START;
    w_h_act  = (h_count >= H_START) && (w_hx < H_WIDTH);
    w_v_act  = (v_count >= V_START) && (w_vy < V_WIDTH);
    w_active = w_h_act && w_v_act;
    w_col    = w_hx / PX;
    w_row    = w_vy / PX;
    w_grid   = ((w_hx % PX) == 16'd0) || ((w_vy % PX) == 16'd0);
    w_idx    = 10'(w_row * 16'(GRID_W) + w_col);
    w_front  = r_bank_sel ? r_bank1 : r_bank0;
    w_cell   = 1'b0;
    if (w_active) w_cell = w_front[w_idx];
  end

  always_comb begin
    w_rgb = 12'h000;
    if (r_s1_active) begin
      if (SHOW_GRID && r_s1_grid) w_rgb = GRID_RGB;
      else                        w_rgb = r_s1_cell ? ALIVE_RGB : DEAD_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_active <= 1'b0;
      r_s1_grid   <= 1'b0;
      r_s1_cell   <= 1'b0;
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_rgb       <= 12'h000;
    end else if (use_enable) begin
      r_s1_active <= w_active;
      r_s1_grid   <= w_grid;
      r_s1_cell   <= w_cell;
      r_s1_hsync  <= h_count < 16'(H_SYNC_END);
      r_s1_vsync  <= v_count < 16'(V_SYNC_END);
      r_hsync     <= r_s1_hsync;
      r_vsync     <= r_s1_vsync;
      r_rgb       <= w_rgb;
    end
  end

  assign hsync_vga = r_hsync;
  assign vsync_vga = r_vsync;
  assign r_vga     = r_rgb[11:8];
  assign g_vga     = r_rgb[7:4];
  assign b_vga     = r_rgb[3:0];

endmodule

// File: tb/tb_life_cell_renderer.sv
// Directed bench for life_cell_renderer: table-driven pixel probes plus hand-written
// swap/reset sequences; a second instance exercises grid-line drawing.
module tb_life_cell_renderer;

  logic        clk = 1'b0;
  logic        rst, use_enable, wr_valid, wr_data, swap_req;
  logic [15:0] h_count, v_count;
  logic [9:0]  wr_addr;
  logic        wr_ready, swap_ack, hsync_vga, vsync_vga;
  logic [3:0]  r_vga, g_vga, b_vga;
  logic        g_wr_ready, g_swap_ack, g_hsync, g_vsync;
  logic [3:0]  g_r, g_g, g_b;
  logic [13:0] w_main, w_grid;

  always #5 clk = ~clk;

  life_cell_renderer dut (
    .clk(clk), .rst(rst), .use_enable(use_enable), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .hsync_vga(hsync_vga), .vsync_vga(vsync_vga),
    .r_vga(r_vga), .g_vga(g_vga), .b_vga(b_vga)
  );

  life_cell_renderer #(.SHOW_GRID(1'b1)) dut_grid (
    .clk(clk), .rst(rst), .use_enable(use_enable), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_ready(g_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(g_swap_ack), .hsync_vga(g_hsync), .vsync_vga(g_vsync),
    .r_vga(g_r), .g_vga(g_g), .b_vga(g_b)
  );

  assign w_main = {hsync_vga, vsync_vga, r_vga, g_vga, b_vga};
  assign w_grid = {g_hsync, g_vsync, g_r, g_g, g_b};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One enabled cycle every fourth clock; inputs change and outputs are read at negedge.
  task automatic pix(input int h, input int v);
    h_count    = 16'(h);
    v_count    = 16'(v);
    use_enable = 1'b1;
    @(negedge clk);
    use_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic probe(input int h, input int v);
    pix(h, v);
    pix(100, 10);
  endtask

  task automatic boundary(input logic req, input logic exp_ack, input string nm);
    h_count    = 16'd0;
    v_count    = 16'd0;
    use_enable = 1'b1;
    swap_req   = req;
    @(negedge clk);
    use_enable = 1'b0;
    swap_req   = 1'b0;
    chk({nm, "_ack"}, {31'd0, swap_ack}, {31'd0, exp_ack});
    @(negedge clk);
    chk({nm, "_ack_end"}, {31'd0, swap_ack}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic write(input int addr, input logic d);
    wr_addr  = 10'(addr);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic req_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  typedef struct {
    int          phase;
    logic        grid;
    int          h;
    int          v;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic run_table(input int phase);
    foreach (tbl[i]) begin
      if (tbl[i].phase == phase) begin
        probe(tbl[i].h, tbl[i].v);
        chk($sformatf("vec%0d_h%0d_v%0d", i, tbl[i].h, tbl[i].v),
            {18'd0, tbl[i].grid ? w_grid : w_main}, {18'd0, tbl[i].exp});
      end
    end
  endtask

  initial begin
    // phase 1: front = bank holding only cell 33 (row1,col1)
    tbl.push_back('{1, 1'b0, 164,  55, 14'h0FFF});
    tbl.push_back('{1, 1'b0, 183,  74, 14'h0FFF});
    tbl.push_back('{1, 1'b0, 184,  55, 14'h0000});
    tbl.push_back('{1, 1'b0, 163,  55, 14'h0000});
    tbl.push_back('{1, 1'b0, 164,  75, 14'h0000});
    tbl.push_back('{1, 1'b0, 164,  54, 14'h0000});
    tbl.push_back('{1, 1'b0, 144,  35, 14'h0000});
    tbl.push_back('{1, 1'b0,  50, 300, 14'h2000});
    tbl.push_back('{1, 1'b0, 300,   1, 14'h1000});
    tbl.push_back('{1, 1'b0,  20,   0, 14'h3000});
    tbl.push_back('{1, 1'b0, 783, 514, 14'h0000});
    tbl.push_back('{1, 1'b0, 784,  55, 14'h0000});
    // phase 2: front = bank holding only cell 0; grid instance and plain instance
    tbl.push_back('{2, 1'b1, 164, 200, 14'h0444});
    tbl.push_back('{2, 1'b1, 150,  35, 14'h0444});
    tbl.push_back('{2, 1'b1, 150,  36, 14'h0FFF});
    tbl.push_back('{2, 1'b1, 100,  10, 14'h0000});
    tbl.push_back('{2, 1'b0, 164, 200, 14'h0000});
    tbl.push_back('{2, 1'b0, 150,  35, 14'h0FFF});

    rst = 1'b1; use_enable = 1'b0; wr_valid = 1'b0; wr_data = 1'b0; swap_req = 1'b0;
    wr_addr = '0; h_count = '0; v_count = '0;
    @(negedge clk);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    pix(0, 0);
    pix(0, 0);
    chk("rst_out", {18'd0, w_main}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("post_rst_out", {18'd0, w_main}, 32'd0);
    pix(0, 0);
    chk("sync_lat1", {18'd0, w_main}, 32'd0);
    pix(100, 10);
    chk("sync_lat2", {18'd0, w_main}, 32'h3000);

    write(33, 1'b1);
    req_swap();
    chk("pending_wr_ready", {31'd0, wr_ready}, 32'd0);
    req_swap();
    boundary(1'b0, 1'b1, "swap1");
    chk("swap1_wr_ready", {31'd0, wr_ready}, 32'd1);
    boundary(1'b0, 1'b0, "no_second");
    run_table(1);

    pix(164, 55);
    chk("lat_first", {18'd0, w_main}, 32'd0);
    pix(100, 10);
    chk("lat_second", {18'd0, w_main}, 32'h0FFF);

    write(0, 1'b1);
    probe(144, 35);
    chk("back_hidden", {18'd0, w_main}, 32'd0);
    req_swap();
    boundary(1'b0, 1'b1, "swap2");
    probe(144, 35);
    chk("swap2_cell0", {18'd0, w_main}, 32'h0FFF);
    probe(164, 55);
    chk("swap2_cell33", {18'd0, w_main}, 32'd0);

    boundary(1'b1, 1'b0, "req_on_bnd");
    chk("req_on_bnd_pending", {31'd0, wr_ready}, 32'd0);
    boundary(1'b0, 1'b1, "swap3");
    probe(164, 55);
    chk("swap3_cell33", {18'd0, w_main}, 32'h0FFF);
    probe(144, 35);
    chk("swap3_cell0", {18'd0, w_main}, 32'd0);

    chk("oob_wr_ready", {31'd0, wr_ready}, 32'd1);
    write(800, 1'b1);
    req_swap();
    boundary(1'b0, 1'b1, "swap4");
    probe(144, 55);
    chk("oob_cell32", {18'd0, w_main}, 32'd0);
    probe(164, 55);
    chk("swap4_cell33", {18'd0, w_main}, 32'd0);
    run_table(2);

    req_swap();
    chk("rst_pend_wr_ready", {31'd0, wr_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pend_ack", {31'd0, swap_ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pend_cleared", {31'd0, wr_ready}, 32'd1);
    boundary(1'b0, 1'b0, "rst_no_swap");
    probe(144, 35);
    chk("rst_bank0_clear", {18'd0, w_main}, 32'd0);
    req_swap();
    boundary(1'b0, 1'b1, "swap5");
    probe(164, 55);
    chk("rst_bank1_clear", {18'd0, w_main}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
